// File: rtl/camera_reset_seq_pkg.sv
// Shared types and constants for the camera reset sequencer.
// Build option: define CAMERA_RESET_SEQ_VERIFY_EN to add the PIO readback check.
package camera_reset_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ASSERT  = 3'd1,
        ST_HOLD    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_SETTLE  = 3'd4,
        ST_VERIFY  = 3'd5,
        ST_DONE    = 3'd6
    } state_e;

    localparam logic [1:0]  PIO_ADDR_RESET    = 2'd0;
    localparam logic [31:0] RESET_ASSERT_VAL  = 32'h0;
    localparam logic [31:0] RESET_RELEASE_VAL = 32'h1;

endpackage

// File: rtl/camera_reset_seq_timer.sv
// Load/decrement wait counter with a zero flag, shared by the HOLD and SETTLE waits.
// Build option: none (CAMERA_RESET_SEQ_VERIFY_EN is handled in the top).
module camera_reset_seq_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load)
            count_d = load_val;
        else if (dec && (count_q != '0))
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) count_q <= '0;
        else          count_q <= count_d;
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/camera_reset_sequencer.sv
// Drives a camera reset PIO over Avalon-MM: assert, hold, release, settle, optional readback.
// Build option: CAMERA_RESET_SEQ_VERIFY_EN enables the VERIFY state and the sticky error flag.
module camera_reset_sequencer
    import camera_reset_seq_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES   = 1000,
    parameter int unsigned SETTLE_CYCLES = 5000,
    parameter int unsigned CNT_W         = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata,
    input  logic        m_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        error
);

    // Counter runs N-1 down to 0 so each wait lasts exactly N cycles.
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic             busy_q, busy_d;
    logic             tmr_load, tmr_dec, tmr_zero;
    logic [CNT_W-1:0] tmr_val, tmr_count;
    logic             err_set;

    camera_reset_seq_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .count    (tmr_count),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_dec  = 1'b0;
        err_set  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_ASSERT;
            end
            ST_ASSERT: begin
                if (!m_waitrequest) begin
                    state_d  = ST_HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (tmr_zero) state_d = ST_RELEASE;
                else          tmr_dec = 1'b1;
            end
            ST_RELEASE: begin
                if (!m_waitrequest) begin
                    state_d  = ST_SETTLE;
                    tmr_load = 1'b1;
                    tmr_val  = SETTLE_LOAD;
                end
            end
            ST_SETTLE: begin
                if (tmr_zero) begin
`ifdef CAMERA_RESET_SEQ_VERIFY_EN
                    state_d = ST_VERIFY;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    tmr_dec = 1'b1;
                end
            end
`ifdef CAMERA_RESET_SEQ_VERIFY_EN
            ST_VERIFY: begin
                if (!m_waitrequest) begin
                    if (m_readdata[0]) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_IDLE;
                        err_set = 1'b1;
                    end
                end
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
        end
    end

    // Bus is decoded from the state register so an async reset clears it at once.
    always_comb begin
        m_address    = '0;
        m_chipselect = 1'b0;
        m_write_n    = 1'b1;
        m_writedata  = '0;
        case (state_q)
            ST_ASSERT: begin
                m_address    = PIO_ADDR_RESET;
                m_chipselect = 1'b1;
                m_write_n    = 1'b0;
                m_writedata  = RESET_ASSERT_VAL;
            end
            ST_RELEASE: begin
                m_address    = PIO_ADDR_RESET;
                m_chipselect = 1'b1;
                m_write_n    = 1'b0;
                m_writedata  = RESET_RELEASE_VAL;
            end
`ifdef CAMERA_RESET_SEQ_VERIFY_EN
            ST_VERIFY: begin
                m_address    = PIO_ADDR_RESET;
                m_chipselect = 1'b1;
            end
`endif
            default: ;
        endcase
    end

`ifdef CAMERA_RESET_SEQ_VERIFY_EN
    logic error_q, error_d;

    always_comb begin
        error_d = error_q;
        if ((state_q == ST_IDLE) && start) error_d = 1'b0;
        if (err_set)                       error_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) error_q <= 1'b0;
        else          error_q <= error_d;
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    assign busy = busy_q;
    assign done = (state_q == ST_DONE);

    logic unused_sink;
    assign unused_sink = ^{m_readdata, tmr_count, err_set};

endmodule
